// File: rtl/t2s_pkg.sv
// Shared types and constants for the T2S pass sequencer: FSM state,
// vector geometry and the effective-pass-count rule.
package t2s_pkg;

  localparam int VEC_LEN           = 32;
  localparam int IDX_W             = 5;
  localparam int DEFAULT_MAX_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Number of passes actually run: the request is clamped so the deepest
  // stage never exceeds max_depth. A first depth beyond the limit runs none.
  function automatic logic [2:0] eff_passes(input logic [2:0] first,
                                            input logic [2:0] num,
                                            input int         max_depth);
    int lim;
    if (int'(first) > max_depth) return 3'd0;
    lim = max_depth + 1 - int'(first);
    return (int'(num) < lim) ? num : 3'(lim);
  endfunction

endpackage

// File: rtl/t2s_stage_perm.sv
// One butterfly-style stage permutation at a runtime-selected depth.
// Only the leading 32>>depth elements move; the tail passes straight through.
module t2s_stage_perm
  import t2s_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]              depth,
  input  logic signed [WIDTH-1:0] cur [VEC_LEN],
  output logic signed [WIDTH-1:0] nxt [VEC_LEN]
);

  always_comb begin
    int len;
    int half;
    int p;
    int dst;
    len  = VEC_LEN >> depth;
    half = len / 2;
    p    = 0;
    dst  = 0;
    // NOTE: nxt gets a full default before the scatter loop so every element
    // is assigned on every path; this is what keeps the block free of latches.
    nxt  = cur;
    for (int pos = 0; pos < VEC_LEN; pos++) begin
      if (pos < len) begin
        p = pos % 2;
        if (pos < half) dst = 2 * pos - p;
        else            dst = len - 1 - 2 * (pos - p - half) - (1 - p);
        // At a two-element segment the formula leaves the segment; the odd
        // element then keeps its slot, which is the only valid permutation.
        if (dst >= 0 && dst < len) nxt[IDX_W'(dst)] = cur[IDX_W'(pos)];
      end
    end
  end

endmodule

// File: rtl/t2s_pass_sequencer.sv
// Accepts a 32-element vector and applies a configured run of stage
// permutations, one per cycle, then holds the result until it is taken.
module t2s_pass_sequencer
  import t2s_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_DEPTH = DEFAULT_MAX_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_vector [VEC_LEN],
  input  logic [2:0]              cfg_first_depth,
  input  logic [2:0]              cfg_num_passes,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_vector [VEC_LEN],
  output logic                    busy,
  output logic [2:0]              pass_idx
);

  state_t                  state_q;
  logic [2:0]              first_q;
  logic [2:0]              passes_q;
  logic [2:0]              accept_passes;
  logic [2:0]              stage_depth;
  logic signed [WIDTH-1:0] data_q    [VEC_LEN];
  logic signed [WIDTH-1:0] stage_out [VEC_LEN];

  assign accept_passes = eff_passes(cfg_first_depth, cfg_num_passes, MAX_DEPTH);
  assign stage_depth   = first_q + pass_idx;

  t2s_stage_perm #(.WIDTH(WIDTH)) u_stage (
    .depth (stage_depth),
    .cur   (data_q),
    .nxt   (stage_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pass_idx <= '0;
      first_q  <= '0;
      passes_q <= '0;
      // NOTE: the data register is reset deliberately so a reset mid-run
      // discards the vector in flight; it is a flop array, not a RAM.
      data_q   <= '{default: '0};
    end else if (flush) begin
      // Flush abandons the run but leaves the data register as it stands.
      state_q  <= ST_IDLE;
      pass_idx <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            data_q   <= in_vector;
            first_q  <= cfg_first_depth;
            passes_q <= accept_passes;
            pass_idx <= '0;
            state_q  <= (accept_passes != 3'd0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          data_q <= stage_out;
          if (pass_idx == passes_q - 3'd1) begin
            pass_idx <= '0;
            state_q  <= ST_DONE;
          end else begin
            pass_idx <= pass_idx + 3'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          pass_idx <= '0;
        end
      endcase
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign out_vector = data_q;

endmodule

// File: tb/tb_t2s_pass_sequencer.sv
// Directed bench for t2s_pass_sequencer: latency, permutation results,
// clamping, back-pressure, flush and reset recovery.
module tb_t2s_pass_sequencer;

  typedef logic signed [15:0] vec_t [32];

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  vec_t       in_vector;
  logic [2:0] cfg_first_depth;
  logic [2:0] cfg_num_passes;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  vec_t       out_vector;
  logic       busy;
  logic [2:0] pass_idx;

  int checks = 0;
  int errors = 0;

  vec_t vi, vneg, vjunk, vzero;

  t2s_pass_sequencer #(.WIDTH(16), .MAX_DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_vector       (in_vector),
    .cfg_first_depth (cfg_first_depth),
    .cfg_num_passes  (cfg_num_passes),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_vector      (out_vector),
    .busy            (busy),
    .pass_idx        (pass_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Closed-form stage result: with L = 32>>d, each group of four output
  // slots k takes the k-th even/odd pair from the front and the k-th pair
  // counted back from the end of the segment.
  function automatic vec_t model(input vec_t v, input int d);
    vec_t r;
    int   len;
    r   = v;
    len = 32 >> d;
    for (int k = 0; k < len / 4; k++) begin
      r[4*k]   = v[2*k];
      r[4*k+1] = v[2*k+1];
      r[4*k+2] = v[len-2-2*k];
      r[4*k+3] = v[len-1-2*k];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t exp);
    logic [511:0] o;
    logic [511:0] e;
    int           bad;
    bad = 0;
    for (int i = 31; i >= 0; i--) begin
      o[i*16 +: 16] = out_vector[i];
      e[i*16 +: 16] = exp[i];
      if (out_vector[i] !== exp[i]) bad = i;
    end
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s idx=%0d observed=%0h expected=%0h", tag, bad, out_vector[bad], exp[bad]);
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge
  // where out_valid is first seen (bounded), config scrambled after accept.
  task automatic launch(input string tag, input vec_t vin, input logic [2:0] first,
                        input logic [2:0] num, input int p_exp);
    int n;
    n               = 0;
    in_vector       = vin;
    cfg_first_depth = first;
    cfg_num_passes  = num;
    in_valid        = 1'b1;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      in_valid        = 1'b0;
      cfg_first_depth = 3'd7;
      cfg_num_passes  = 3'd7;
      in_vector       = vjunk;
    end while (!out_valid && n < 20);
    check({tag, " latency"}, n, p_exp + 1);
  endtask

  task automatic take_output(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " idle after take"}, {29'd0, in_ready, out_valid, busy}, 32'b100);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      vi[i]    = 16'(i);
      vneg[i]  = 16'(5 - 3 * i);
      vjunk[i] = 16'(16'h5a00 + i);
      vzero[i] = 16'sd0;
    end
    rst             = 1'b1;
    in_valid        = 1'b0;
    in_vector       = vzero;
    cfg_first_depth = 3'd0;
    cfg_num_passes  = 3'd0;
    flush           = 1'b0;
    out_ready       = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset flags", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'b1000);
    check("reset pass_idx", pass_idx, 0);
    check_vec("reset data", vzero);
    rst = 1'b0;
    @(negedge clk);
    check("idle no valid", {29'd0, in_ready, out_valid, busy}, 32'b100);

    // Single pass at depth 0
    launch("d0", vi, 3'd0, 3'd1, 1);
    check("d0 out0", out_vector[0], 32'd0);
    check("d0 out4", out_vector[4], 32'd2);
    check("d0 out2", out_vector[2], 32'd30);
    check("d0 out3", out_vector[3], 32'd31);
    check_vec("d0 vec", model(vi, 0));
    take_output("d0");

    // Single pass at depth 2
    launch("d2", vi, 3'd2, 3'd1, 1);
    check("d2 out2", out_vector[2], 32'd6);
    check("d2 out3", out_vector[3], 32'd7);
    check("d2 out4", out_vector[4], 32'd2);
    check("d2 out7", out_vector[7], 32'd5);
    check("d2 out8", out_vector[8], 32'd8);
    check_vec("d2 vec", model(vi, 2));
    take_output("d2");

    // Signed data at depth 1, and a chained two-pass run
    launch("d1 neg", vneg, 3'd1, 3'd1, 1);
    check_vec("d1 neg vec", model(vneg, 1));
    take_output("d1 neg");
    launch("d0d1", vneg, 3'd0, 3'd2, 2);
    check_vec("d0d1 vec", model(model(vneg, 0), 1));
    take_output("d0d1");

    // Zero passes and clamping
    launch("p0", vneg, 3'd0, 3'd0, 0);
    check_vec("p0 vec", vneg);
    take_output("p0");
    launch("clamp3", vi, 3'd3, 3'd7, 2);
    check_vec("clamp3 vec", model(model(vi, 3), 4));
    take_output("clamp3");
    launch("clamp4", vneg, 3'd4, 3'd7, 1);
    check_vec("clamp4 vec", model(vneg, 4));
    take_output("clamp4");
    launch("first5", vi, 3'd5, 3'd3, 0);
    check_vec("first5 vec", vi);
    take_output("first5");

    // Flush at pass 1
    in_vector       = vi;
    cfg_first_depth = 3'd0;
    cfg_num_passes  = 3'd3;
    in_valid        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("run pass0 idx", pass_idx, 0);
    check("run pass0 flags", {29'd0, in_ready, out_valid, busy}, 32'b001);
    @(posedge clk);
    @(negedge clk);
    check("run pass1 idx", pass_idx, 1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
    check("flush pass_idx", pass_idx, 0);
    check_vec("flush data kept", model(vi, 0));
    @(posedge clk);
    @(negedge clk);
    check("flush no out_valid", out_valid, 0);
    // Flush beats an accept in the same cycle
    in_vector = vneg;
    in_valid  = 1'b1;
    flush     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush over accept", {29'd0, in_ready, out_valid, busy}, 32'b100);
    launch("after flush", vneg, 3'd0, 3'd1, 1);
    check_vec("after flush vec", model(vneg, 0));
    take_output("after flush");

    // Reset mid-run
    in_vector       = vneg;
    cfg_first_depth = 3'd0;
    cfg_num_passes  = 3'd3;
    in_valid        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("rst run flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
    check("rst run pass_idx", pass_idx, 0);
    check_vec("rst run data", vzero);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst run no out_valid", out_valid, 0);
    launch("after rst", vi, 3'd2, 3'd1, 1);
    check_vec("after rst vec", model(vi, 2));
    take_output("after rst");

    // Back-pressure in DONE with a pending input held valid
    launch("hold", vi, 3'd0, 3'd1, 1);
    in_vector       = vneg;
    cfg_first_depth = 3'd2;
    cfg_num_passes  = 3'd1;
    in_valid        = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      check_vec("hold vec stable", model(vi, 0));
      check("hold in_ready", {30'd0, in_ready, out_valid}, 32'b01);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("no same-cycle accept", {29'd0, in_ready, out_valid, busy}, 32'b100);
    launch("held accept", vneg, 3'd2, 3'd1, 1);
    check_vec("held accept vec", model(vneg, 2));
    take_output("held accept");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/t2s_pass_sequencer.md
T2S_PASS_SEQUENCER -- requirements
Module: t2s_pass_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, signed element width.
REQ-002 SHALL have parameter MAX_DEPTH, default 4, deepest permitted stage depth.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  the input vector and config are valid.
REQ-006 SHALL have port in_ready  output  1  the block accepts a vector this cycle.
REQ-007 SHALL have port in_vector  input  32 x WIDTH signed  the source vector.
REQ-008 SHALL have port cfg_first_depth  input  3  the depth of the first pass, sampled on accept.
REQ-009 SHALL have port cfg_num_passes  input  3  the requested pass count, sampled on accept.
REQ-010 SHALL have port flush  input  1  synchronous abort to IDLE.
REQ-011 SHALL have port out_valid  output  1  out_vector holds the final result.
REQ-012 SHALL have port out_ready  input  1  the downstream consumer takes the result.
REQ-013 SHALL have port out_vector  output  32 x WIDTH signed  the registered result.
REQ-014 SHALL have port busy  output  1  high in RUN or DONE.
REQ-015 SHALL have port pass_idx  output  3  the current pass index in RUN, 0 otherwise.

Function
REQ-016 Stage permutation at depth d SHALL be: L=32>>d, N=L; for pos<L, R=pos, p=R mod 2; if R<N/2 then new=2R-p, else new=N-1-2(R-p-N/2)-(1-p); next[new]=cur[pos]; positions >= L SHALL be unchanged.
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE. in_ready SHALL equal (state==IDLE). out_valid SHALL equal (state==DONE).
REQ-018 On the accept cycle T (IDLE and in_valid): in_vector SHALL be loaded into the data register. The effective pass count P SHALL be min(cfg_num_passes, MAX_DEPTH+1-cfg_first_depth), or 0 if cfg_first_depth>MAX_DEPTH. The next state SHALL be RUN if P>0, else DONE.
REQ-019 In RUN, each cycle SHALL apply one stage at depth cfg_first_depth+pass_idx to the register and increment pass_idx. After pass P-1 the next state SHALL be DONE.
REQ-020 Latency: out_valid SHALL rise at cycle T+1+P.
REQ-021 In DONE, out_vector SHALL stay stable until out_ready. On out_ready the next state SHALL be IDLE. There SHALL be no same-cycle re-accept; the earliest next accept is at T_done+1.
REQ-022 flush SHALL force IDLE next cycle from any state and clear pass_idx. The data register SHALL be left unchanged. flush SHALL override an accept or out_ready in the same cycle.
REQ-023 Config inputs SHALL be ignored outside the accept cycle.

Reset
REQ-024 While rst is high: state SHALL be IDLE, pass_idx 0, data register all-zero, out_valid 0, busy 0, in_ready 1.
REQ-025 Reset asserted mid-RUN or in DONE SHALL discard the vector in flight with no output.

Structure
REQ-026 The package t2s_pkg SHALL hold the state enum, VEC_LEN=32 and the default MAX_DEPTH.
REQ-027 The stage permutation SHALL be the combinational sub-module t2s_stage_perm, with a runtime depth input, instantiated once.

Verification
REQ-028 in[i]=i, first=0, passes=1: out_valid at T+2; out[0]=0, out[4]=2, out[2]=30, out[3]=31.
REQ-029 in[i]=i, first=2, passes=1: out[2..7]=6,7,2,3,4,5; out[8..31]=8..31.
REQ-030 passes=0: out_vector equals in_vector and out_valid at T+1.
REQ-031 first=3, passes=7: P clamps to 2 and out_valid at T+3. first=5: P=0.
REQ-032 out_ready held low 5 cycles in DONE: out_vector stable, in_ready=0, the held in_valid is not accepted until the cycle after the handshake.
REQ-033 flush at RUN pass 1, and a separate rst pulse mid-RUN: IDLE next cycle, out_valid never asserted, the new vector is accepted and processed correctly.
